mem_responder: RTL and testbench

Memory-side responder for the pipelined datapath's two request ports (instruction fetch and data load/store). It answers one outstanding request at a time over a single-ported, word-wide backing memory bus (pmem_*) with byte enables. Each served request returns a one-cycle response pulse and registered read data to the requesting port. It sits between the datapath and the physical memory or the cache hierarchy.

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 51 +++++
 rtl/mem_responder.sv | 112 +++++++++++
 tb/tb_mem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: word/mask types, FSM state encoding, address helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_responder_pkg;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mask;

  // Responder FSM state. Plain logic vector so legacy code can compare against raw encodings.
  typedef logic [2:0] memresp_state_t;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DATA_XFER = 3'd1;
  localparam logic [2:0] INST_XFER = 3'd2;
  localparam logic [2:0] DATA_RESP = 3'd3;
  localparam logic [2:0] INST_RESP = 3'd4;

  // Instruction fetches always move a whole word.
  localparam rv32i_mask FULL_WORD_MASK = 4'b1111;

  // The backing bus is word addressed; the low two bits never leave the responder.
  function automatic rv32i_word word_align(input rv32i_word addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Bundle of the datapath request ports and the backing memory bus seen by the responder.
// Latency: n/a (wiring only).
// Backpressure: requesters hold a request until their resp pulse; pmem holds the strobe until pmem_resp.
interface mem_responder_if;
  import mem_responder_pkg::*;

  // instruction fetch port
  logic      inst_mem_read;
  rv32i_word inst_mem_address;
  logic      inst_mem_resp;
  rv32i_word inst_mem_rdata;

  // data load/store port
  logic      data_mem_read;
  logic      data_mem_write;
  rv32i_word data_mem_address;
  rv32i_word data_mem_wdata;
  rv32i_mask mem_byte_enable;
  logic      data_mem_resp;
  rv32i_word data_mem_rdata;

  // backing memory bus
  logic      pmem_read;
  logic      pmem_write;
  rv32i_word pmem_address;
  rv32i_word pmem_wdata;
  rv32i_mask pmem_byte_enable;
  logic      pmem_resp;
  rv32i_word pmem_rdata;

  // Responder side.
  modport slave (
    input  inst_mem_read, inst_mem_address,
    input  data_mem_read, data_mem_write, data_mem_address, data_mem_wdata, mem_byte_enable,
    input  pmem_resp, pmem_rdata,
    output inst_mem_resp, inst_mem_rdata,
    output data_mem_resp, data_mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable
  );

  // Datapath plus backing memory side.
  modport master (
    output inst_mem_read, inst_mem_address,
    output data_mem_read, data_mem_write, data_mem_address, data_mem_wdata, mem_byte_enable,
    output pmem_resp, pmem_rdata,
    input  inst_mem_resp, inst_mem_rdata,
    input  data_mem_resp, data_mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable
  );

endinterface

// File: rtl/mem_responder.sv
// Serves one fetch or load/store at a time over a single word-wide backing bus; data beats fetch.
// Latency: request sampled in IDLE at cycle 0, strobe from cycle 1, resp one cycle after pmem_resp.
// Backpressure: strobe held until pmem_resp; requesters hold their request until their resp pulse.
module mem_responder
  import mem_responder_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  memresp_state_t state;
  memresp_state_t state_next;

  logic      data_req;
  logic      pmem_read_q;
  logic      pmem_write_q;
  rv32i_word pmem_address_q;
  rv32i_word pmem_wdata_q;
  rv32i_mask pmem_byte_enable_q;
  rv32i_word inst_rdata_q;
  rv32i_word data_rdata_q;

  // A store wins over a simultaneous load, so any data strobe counts as a data request.
  assign data_req = bus.data_mem_read | bus.data_mem_write;

  // Next-state: data has fixed priority in IDLE; RESP states always fall back to IDLE so a
  // request still high there is not served twice.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (data_req)               state_next = DATA_XFER;
        else if (bus.inst_mem_read) state_next = INST_XFER;
      end
      DATA_XFER: if (bus.pmem_resp) state_next = DATA_RESP;
      INST_XFER: if (bus.pmem_resp) state_next = INST_RESP;
      DATA_RESP: state_next = IDLE;
      INST_RESP: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Latch the accepted request into the pmem drive registers and drop the strobe on pmem_resp.
  // The latch happens only in IDLE, so requester changes during XFER cannot reach the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pmem_read_q        <= 1'b0;
      pmem_write_q       <= 1'b0;
      pmem_address_q     <= '0;
      pmem_wdata_q       <= '0;
      pmem_byte_enable_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req) begin
            pmem_address_q     <= word_align(bus.data_mem_address);
            pmem_wdata_q       <= bus.data_mem_wdata;
            pmem_byte_enable_q <= bus.mem_byte_enable;
            pmem_write_q       <= bus.data_mem_write;
            pmem_read_q        <= ~bus.data_mem_write;
          end else if (bus.inst_mem_read) begin
            pmem_address_q     <= word_align(bus.inst_mem_address);
            pmem_wdata_q       <= '0;
            pmem_byte_enable_q <= FULL_WORD_MASK;
            pmem_write_q       <= 1'b0;
            pmem_read_q        <= 1'b1;
          end
        end
        DATA_XFER, INST_XFER: begin
          if (bus.pmem_resp) begin
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
          end
        end
        default: begin
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  // Capture read data into the port that asked for it; stores leave data_mem_rdata alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else if (bus.pmem_resp && pmem_read_q) begin
      if (state == INST_XFER) inst_rdata_q <= bus.pmem_rdata;
      if (state == DATA_XFER) data_rdata_q <= bus.pmem_rdata;
    end
  end

  // Response pulses decode straight from the state register: one cycle each, never together.
  assign bus.inst_mem_resp    = (state == INST_RESP);
  assign bus.data_mem_resp    = (state == DATA_RESP);
  assign bus.inst_mem_rdata   = inst_rdata_q;
  assign bus.data_mem_rdata   = data_rdata_q;
  assign bus.pmem_read        = pmem_read_q;
  assign bus.pmem_write       = pmem_write_q;
  assign bus.pmem_address     = pmem_address_q;
  assign bus.pmem_wdata       = pmem_wdata_q;
  assign bus.pmem_byte_enable = pmem_byte_enable_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: memory model on pmem, scoreboard of expected responses.
// Latency: checks strobe/resp cycle numbers relative to the request cycle.
// Backpressure: requests are held until their resp pulse, then dropped.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if bus();

  mem_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit          is_inst;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pm_log[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          resp_cnt = 0;
  int          mem_lat = 1;
  bit          mem_auto = 1'b1;
  logic        man_resp = 1'b0;
  logic [31:0] last_data = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Backing memory: answers mem_lat cycles into a strobe (1 = same cycle as the strobe rises).
  initial begin
    int  m_cnt;
    bit  m_done;
    m_cnt = 0;
    m_done = 1'b0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!(bus.pmem_read || bus.pmem_write)) begin
        m_cnt  = 0;
        m_done = 1'b0;
      end
      if (!mem_auto) begin
        bus.pmem_resp  = man_resp;
        bus.pmem_rdata = 32'hBAD0_BAD0;
      end else begin
        bus.pmem_resp = 1'b0;
        if ((bus.pmem_read || bus.pmem_write) && !m_done) begin
          m_cnt++;
          if (m_cnt >= mem_lat) begin
            bus.pmem_resp = 1'b1;
            pm_log.push_back(bus.pmem_address);
            m_done = 1'b1;
            if (bus.pmem_write) begin
              mem[bus.pmem_address] = merge(mem_rd(bus.pmem_address), bus.pmem_wdata, bus.pmem_byte_enable);
              bus.pmem_rdata = 32'hBAD0_BAD0;
            end else begin
              bus.pmem_rdata = mem_rd(bus.pmem_address);
            end
          end
        end
      end
    end
  end

  // Monitor: bus exclusivity every cycle, scoreboard pop on every response pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.pmem_read || bus.pmem_write)
        chk("pmem_strobe_excl", 32'(bus.pmem_read & bus.pmem_write), 32'h0);
      if (bus.inst_mem_resp || bus.data_mem_resp) begin
        resp_cnt++;
        chk("resp_excl", 32'(bus.inst_mem_resp & bus.data_mem_resp), 32'h0);
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'h1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("resp_port", 32'(bus.inst_mem_resp), 32'(e.is_inst));
          if (e.is_inst) chk("inst_rdata", bus.inst_mem_rdata, e.rdata);
          else           chk("data_rdata", bus.data_mem_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input bit is_inst, input bit wr, input logic [31:0] addr);
    exp_t e;
    e.is_inst = is_inst;
    if (!is_inst && wr) e.rdata = last_data;
    else                e.rdata = mem_rd(addr);
    if (!is_inst) last_data = e.rdata;
    sb_q.push_back(e);
  endtask

  task automatic chk_reset_vals();
    chk("rst_state",   32'(dut.state), 32'(IDLE));
    chk("rst_iresp",   32'(bus.inst_mem_resp), 32'h0);
    chk("rst_dresp",   32'(bus.data_mem_resp), 32'h0);
    chk("rst_pread",   32'(bus.pmem_read), 32'h0);
    chk("rst_pwrite",  32'(bus.pmem_write), 32'h0);
    chk("rst_paddr",   bus.pmem_address, 32'h0);
    chk("rst_pwdata",  bus.pmem_wdata, 32'h0);
    chk("rst_pbe",     32'(bus.pmem_byte_enable), 32'h0);
    chk("rst_irdata",  bus.inst_mem_rdata, 32'h0);
    chk("rst_drdata",  bus.data_mem_rdata, 32'h0);
  endtask

  // One request through to its response; checks the strobe fields on every strobe cycle.
  task automatic do_req(input bit is_inst, input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input int lat,
                        output int s_rel, output int r_rel);
    int c0;
    mem_lat = lat;
    @(posedge clk);
    #1;
    c0 = cyc;
    if (is_inst) begin
      bus.inst_mem_read    = 1'b1;
      bus.inst_mem_address = addr;
    end else begin
      bus.data_mem_read    = rd;
      bus.data_mem_write   = wr;
      bus.data_mem_address = addr;
      bus.data_mem_wdata   = wd;
      bus.mem_byte_enable  = be;
    end
    push_exp(is_inst, wr, addr);
    s_rel = -1;
    r_rel = -1;
    for (int i = 0; i < 40 && r_rel < 0; i++) begin
      @(negedge clk);
      if (bus.pmem_read || bus.pmem_write) begin
        chk("req_paddr", bus.pmem_address, addr);
        if (s_rel < 0) begin
          s_rel = cyc - c0;
          chk("req_pread",  32'(bus.pmem_read),  32'(is_inst || !wr));
          chk("req_pwrite", 32'(bus.pmem_write), 32'(!is_inst && wr));
          chk("req_pbe",    32'(bus.pmem_byte_enable), is_inst ? 32'hF : 32'(be));
          if (!is_inst && wr) chk("req_pwdata", bus.pmem_wdata, wd);
        end
      end
      if (is_inst ? bus.inst_mem_resp : bus.data_mem_resp) begin
        r_rel = cyc - c0;
        bus.inst_mem_read  = 1'b0;
        bus.data_mem_read  = 1'b0;
        bus.data_mem_write = 1'b0;
      end
    end
    chk("req_completed", 32'(r_rel >= 0), 32'h1);
  endtask

  initial begin
    int s_rel, r_rel, c0, ds, dr, is, ir, n;
    int rc[3];
    logic [31:0] fa;
    bus.inst_mem_read    = 1'b0;
    bus.inst_mem_address = 32'h0;
    bus.data_mem_read    = 1'b0;
    bus.data_mem_write   = 1'b0;
    bus.data_mem_address = 32'h0;
    bus.data_mem_wdata   = 32'h0;
    bus.mem_byte_enable  = 4'h0;
    mem[32'h104] = 32'hDEAD_BEEF;

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load with pmem_resp three cycles in.
    do_req(1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'hF, 3, s_rel, r_rel);
    chk("load_strobe_cyc", 32'(s_rel), 32'd1);
    chk("load_resp_cyc",   32'(r_rel), 32'd4);
    chk("load_rdata_lit",  bus.data_mem_rdata, 32'hDEAD_BEEF);

    // Store: single lane, data_mem_rdata must stay at the loaded word.
    do_req(1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h00AB_0000, 4'b0100, 2, s_rel, r_rel);
    chk("store_strobe_cyc", 32'(s_rel), 32'd1);
    chk("store_resp_cyc",   32'(r_rel), 32'd3);

    // Read the stored word back: only lane 2 changed.
    do_req(1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 1, s_rel, r_rel);
    chk("readback_resp_cyc", 32'(r_rel), 32'd2);

    // Read and write together: served as a store, rdata unchanged.
    do_req(1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h1111_2222, 4'b0011, 1, s_rel, r_rel);
    chk("rw_resp_cyc", 32'(r_rel), 32'd2);

    // Contention: data first, fetch sampled in the IDLE after data_mem_resp.
    mem_lat = 1;
    @(posedge clk);
    #1;
    c0 = cyc;
    bus.data_mem_read    = 1'b1;
    bus.data_mem_address = 32'h0000_0120;
    bus.inst_mem_read    = 1'b1;
    bus.inst_mem_address = 32'h0000_0080;
    push_exp(1'b0, 1'b0, 32'h0000_0120);
    push_exp(1'b1, 1'b0, 32'h0000_0080);
    ds = -1; dr = -1; is = -1; ir = -1;
    for (int i = 0; i < 40 && ir < 0; i++) begin
      @(negedge clk);
      if (bus.pmem_read && bus.pmem_address == 32'h120 && ds < 0) ds = cyc - c0;
      if (bus.pmem_read && bus.pmem_address == 32'h80 && is < 0) is = cyc - c0;
      if (bus.data_mem_resp) begin dr = cyc - c0; bus.data_mem_read = 1'b0; end
      if (bus.inst_mem_resp) begin ir = cyc - c0; bus.inst_mem_read = 1'b0; end
    end
    chk("cont_data_strobe", 32'(ds), 32'd1);
    chk("cont_data_resp",   32'(dr), 32'd2);
    chk("cont_inst_strobe", 32'(is), 32'd4);
    chk("cont_inst_resp",   32'(ir), 32'd5);

    // Back-to-back fetches, pmem answering in the strobe's first cycle.
    pm_log.delete();
    mem_lat = 1;
    @(posedge clk);
    #1;
    c0 = cyc;
    fa = 32'h0;
    bus.inst_mem_read    = 1'b1;
    bus.inst_mem_address = fa;
    push_exp(1'b1, 1'b0, fa);
    n = 0;
    rc[0] = -1; rc[1] = -1; rc[2] = -1;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (bus.inst_mem_resp) begin
        rc[n] = cyc - c0;
        n++;
        if (n < 3) begin
          fa = fa + 32'h4;
          bus.inst_mem_address = fa;
          push_exp(1'b1, 1'b0, fa);
        end else begin
          bus.inst_mem_read = 1'b0;
        end
      end
    end
    chk("b2b_resp0", 32'(rc[0]), 32'd2);
    chk("b2b_resp1", 32'(rc[1]), 32'd5);
    chk("b2b_resp2", 32'(rc[2]), 32'd8);
    repeat (3) @(negedge clk);
    chk("b2b_fetch_count", 32'(pm_log.size()), 32'd3);
    if (pm_log.size() == 3) begin
      chk("b2b_addr0", pm_log[0], 32'h0);
      chk("b2b_addr1", pm_log[1], 32'h4);
      chk("b2b_addr2", pm_log[2], 32'h8);
    end

    // Reset during DATA_XFER, late pmem_resp must be ignored.
    mem_auto = 1'b0;
    man_resp = 1'b0;
    @(posedge clk);
    #1;
    bus.data_mem_read    = 1'b1;
    bus.data_mem_address = 32'h0000_0300;
    n = resp_cnt;
    @(posedge clk);
    #1;
    chk("abort_strobe_up", 32'(bus.pmem_read), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.data_mem_read = 1'b0;
    #1;
    chk("abort_strobe_drop", 32'(bus.pmem_read | bus.pmem_write), 32'h0);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    man_resp = 1'b1;
    @(posedge clk);
    #1;
    man_resp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_no_resp", 32'(resp_cnt - n), 32'd0);
    chk_reset_vals();
    mem_auto = 1'b1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
